// File: rtl/score_pkg.sv
// Shared types and defaults for the score digit formatter.
// FSM state enum, default widths, saturation limit.
package score_pkg;

  localparam int BIN_WIDTH_DEF  = 14;
  localparam int NUM_DIGITS_DEF = 4;

  function automatic longint pow10_m1(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam longint MAX_VALUE = pow10_m1(NUM_DIGITS_DEF);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    PENDING
  } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// Double-dabble correction: add 3 to every BCD nibble >= 5.
// Ports: i_scratch (BCD in), o_scratch (corrected BCD out).
module bcd_dabble_step
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic [4*NUM_DIGITS-1:0] i_scratch,
  output logic [4*NUM_DIGITS-1:0] o_scratch
);

  always_comb begin
    o_scratch = i_scratch;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i_scratch[4*i +: 4] >= 4'd5)
        o_scratch[4*i +: 4] = i_scratch[4*i +: 4] + 4'd3;
    end
  end

endmodule

// File: rtl/score_digit_formatter.sv
// Binary score -> saturated BCD digits, committed only at frame start.
// Ports: value/valid/ready in, frame_start_in, digits/enable/overflow out, busy.
module score_digit_formatter
  import score_pkg::*;
#(
  parameter int BIN_WIDTH  = BIN_WIDTH_DEF,
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_in,
  input  logic [BIN_WIDTH-1:0]    value_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic                    frame_start_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_en_out,
  output logic                    overflow_out,
  output logic                    busy_out
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam longint MAX_L = pow10_m1(NUM_DIGITS);
  // If the limit exceeds the input range, saturation never triggers.
  localparam logic [BIN_WIDTH-1:0] MAX_BIN =
    (MAX_L >= (longint'(1) << BIN_WIDTH)) ? '1 : BIN_WIDTH'(MAX_L);

  state_t               r_state;
  logic                 r_ready;
  logic [BIN_WIDTH-1:0] r_bin;
  logic [DW-1:0]        r_scratch;
  logic [CW-1:0]        r_cnt;
  logic                 r_ovf;
  logic [DW-1:0]        r_digits;
  logic [NUM_DIGITS-1:0] r_en;
  logic                 r_ovf_out;

  logic [DW-1:0]         w_corr;
  logic [NUM_DIGITS-1:0] w_en;
  logic                  w_ovf;
  logic                  w_accept;

  bcd_dabble_step #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_step (
    .i_scratch(r_scratch),
    .o_scratch(w_corr)
  );

  assign w_ovf    = longint'(value_in) > MAX_L;
  assign w_accept = valid_in && r_ready;

  // A digit is drawn if it or any more significant digit is nonzero.
  always_comb begin : en_blk
    logic any;
    any  = 1'b0;
    w_en = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      any     = any | (r_scratch[4*i +: 4] != 4'd0);
      w_en[i] = any;
    end
    w_en[0] = 1'b1;
  end

  // Ready is a register so it stays low until the first edge after reset.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= IDLE;
      r_ready   <= 1'b0;
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_digits  <= '0;
      r_en      <= NUM_DIGITS'(1);
      r_ovf_out <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready   <= 1'b0;
            r_bin     <= w_ovf ? MAX_BIN : value_in;
            r_ovf     <= w_ovf;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_state   <= CONVERT;
          end
        end
        CONVERT: begin
          // Count reaches BIN_WIDTH after the last shift; one more
          // cycle hands over to PENDING.
          if (r_cnt == CW'(BIN_WIDTH)) begin
            r_state <= PENDING;
          end else begin
            {r_scratch, r_bin} <= {w_corr, r_bin} << 1;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PENDING: begin
          if (frame_start_in) begin
            r_digits  <= r_scratch;
            r_en      <= w_en;
            r_ovf_out <= r_ovf;
            r_ready   <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready_out    = r_ready;
  assign busy_out     = ~r_ready;
  assign digits_out   = r_digits;
  assign digit_en_out = r_en;
  assign overflow_out = r_ovf_out;

endmodule

// File: tb/tb_score_digit_formatter.sv
// Self-checking bench for score_digit_formatter.
// Table vectors, hand corner sequences, random values vs arithmetic model.
module tb_score_digit_formatter;

  logic        clk;
  logic        rst_n;
  logic [13:0] value_in;
  logic        valid_in;
  logic        ready_out;
  logic        frame_start_in;
  logic [15:0] digits_out;
  logic [3:0]  digit_en_out;
  logic        overflow_out;
  logic        busy_out;

  int total;
  int bad;

  score_digit_formatter #(
    .BIN_WIDTH(14),
    .NUM_DIGITS(4)
  ) dut (
    .pixel_clk_in(clk),
    .rst_in(rst_n),
    .value_in(value_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .frame_start_in(frame_start_in),
    .digits_out(digits_out),
    .digit_en_out(digit_en_out),
    .overflow_out(overflow_out),
    .busy_out(busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          v;
    int          fs;
    logic [15:0] d;
    logic [3:0]  e;
    logic        o;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  // Reference: saturate, then split into decimal digits arithmetically.
  task automatic model(input int v, output logic [15:0] d,
                       output logic [3:0] e, output logic o);
    int s;
    int p;
    o = (v > 9999);
    s = o ? 9999 : v;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      d[4*i +: 4] = 4'((s / p) % 10);
      e[i] = (i == 0) || ((s / p) != 0);
      p = p * 10;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!ready_out && n < 100) begin
      tick();
      n++;
    end
    ok = ready_out;
    if (!ok) chk("ready_wait", {31'd0, ready_out}, 32'd1);
  endtask

  // Accept v at edge 0; pulse frame_start at fs (commit) and at
  // p1..p3 (expected to be ignored). Outputs must hold until fs.
  task automatic xfer(input int v, input int fs, input int p1,
                      input int p2, input int p3, input logic [15:0] ed,
                      input logic [3:0] ee, input logic eo);
    bit ok;
    bit stable;
    bit busy_ok;
    logic [15:0] d0;
    logic [3:0]  e0;
    logic        o0;
    wait_ready(ok);
    if (!ok) return;
    d0 = digits_out;
    e0 = digit_en_out;
    o0 = overflow_out;
    valid_in = 1'b1;
    value_in = 14'(v);
    tick();
    valid_in = 1'b0;
    stable  = 1'b1;
    busy_ok = 1'b1;
    for (int k = 1; k <= fs; k++) begin
      frame_start_in = (k == fs) || (k == p1) || (k == p2) || (k == p3);
      if (!busy_out || ready_out) busy_ok = 1'b0;
      tick();
      frame_start_in = 1'b0;
      if (k < fs &&
          (digits_out !== d0 || digit_en_out !== e0 || overflow_out !== o0))
        stable = 1'b0;
    end
    chk("hold_before_commit", {31'd0, stable}, 32'd1);
    chk("busy_while_converting", {31'd0, busy_ok}, 32'd1);
    chk("digits", {16'd0, digits_out}, {16'd0, ed});
    chk("digit_en", {28'd0, digit_en_out}, {28'd0, ee});
    chk("overflow", {31'd0, overflow_out}, {31'd0, eo});
    chk("ready_after_commit", {31'd0, ready_out}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] md;
    logic [3:0]  me;
    logic        mo;
    bit          ok;
    bit          flag;
    int          v;

    total = 0;
    bad = 0;
    rst_n = 1'b0;
    value_in = '0;
    valid_in = 1'b0;
    frame_start_in = 1'b0;

    tbl[0]  = '{1234,  20, 16'h1234, 4'b1111, 1'b0};
    tbl[1]  = '{7,     16, 16'h0007, 4'b0001, 1'b0};
    tbl[2]  = '{12000, 17, 16'h9999, 4'b1111, 1'b1};
    tbl[3]  = '{0,     16, 16'h0000, 4'b0001, 1'b0};
    tbl[4]  = '{9999,  18, 16'h9999, 4'b1111, 1'b0};
    tbl[5]  = '{10000, 16, 16'h9999, 4'b1111, 1'b1};
    tbl[6]  = '{16383, 16, 16'h9999, 4'b1111, 1'b1};
    tbl[7]  = '{10,    16, 16'h0010, 4'b0011, 1'b0};
    tbl[8]  = '{100,   16, 16'h0100, 4'b0111, 1'b0};
    tbl[9]  = '{1000,  19, 16'h1000, 4'b1111, 1'b0};
    tbl[10] = '{9,     16, 16'h0009, 4'b0001, 1'b0};
    tbl[11] = '{805,   25, 16'h0805, 4'b0111, 1'b0};

    // Reset state
    repeat (3) tick();
    chk("rst_ready", {31'd0, ready_out}, 32'd0);
    chk("rst_busy", {31'd0, busy_out}, 32'd1);
    chk("rst_digits", {16'd0, digits_out}, 32'd0);
    chk("rst_en", {28'd0, digit_en_out}, 32'd1);
    chk("rst_ovf", {31'd0, overflow_out}, 32'd0);
    rst_n = 1'b1;
    chk("ready_at_release", {31'd0, ready_out}, 32'd0);
    tick();
    chk("ready_first_edge", {31'd0, ready_out}, 32'd1);

    // Reset aborts an in-flight conversion
    wait_ready(ok);
    valid_in = 1'b1;
    value_in = 14'd4321;
    tick();
    valid_in = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_ready_low", {31'd0, ready_out}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_ready_after", {31'd0, ready_out}, 32'd1);
    flag = 1'b1;
    for (int k = 0; k < 24; k++) begin
      frame_start_in = (k % 4 == 0);
      tick();
      frame_start_in = 1'b0;
      if (digits_out !== 16'h0 || overflow_out !== 1'b0) flag = 1'b0;
    end
    chk("abort_digits_zero", {31'd0, flag}, 32'd1);
    chk("abort_en", {28'd0, digit_en_out}, 32'd1);

    // Table vectors
    for (int i = 0; i < 12; i++)
      xfer(tbl[i].v, tbl[i].fs, 0, 0, 0, tbl[i].d, tbl[i].e, tbl[i].o);

    // Pulses at +5, +14, +15 ignored; +16 commits
    xfer(5678, 16, 5, 14, 15, 16'h5678, 4'b1111, 1'b0);

    // valid_in held high while busy: second value waits for IDLE
    wait_ready(ok);
    valid_in = 1'b1;
    value_in = 14'd42;
    tick();
    value_in = 14'd3071;
    flag = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      frame_start_in = (k == 16);
      if (ready_out) flag = 1'b0;
      tick();
      frame_start_in = 1'b0;
    end
    chk("hold_valid_no_ready", {31'd0, flag}, 32'd1);
    chk("hold_first_digits", {16'd0, digits_out}, 32'h0042);
    chk("hold_first_en", {28'd0, digit_en_out}, 32'b0011);
    tick();
    valid_in = 1'b0;
    chk("hold_second_busy", {31'd0, busy_out}, 32'd1);
    for (int k = 1; k <= 16; k++) begin
      frame_start_in = (k == 16);
      tick();
      frame_start_in = 1'b0;
    end
    chk("hold_second_digits", {16'd0, digits_out}, 32'h3071);
    chk("hold_second_en", {28'd0, digit_en_out}, 32'b1111);

    // Random values against the arithmetic model
    for (int r = 0; r < 24; r++) begin
      v = int'($urandom_range(0, 16383));
      if (r % 4 == 1) v = int'($urandom_range(0, 120));
      model(v, md, me, mo);
      xfer(v, 16 + int'($urandom_range(0, 6)), 0, 0, 0, md, me, mo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_digit_formatter.md
SCORE_DIGIT_FORMATTER -- requirements
Module: score_digit_formatter

Interface
REQ-001 SHALL have parameter BIN_WIDTH, default 14: width of the binary score input.
REQ-002 SHALL have parameter NUM_DIGITS, default 4: number of BCD digits produced, one per numeral sprite.
REQ-003 SHALL have port pixel_clk_in, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_in, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port value_in, input, BIN_WIDTH: binary score to display.
REQ-006 SHALL have port valid_in, input, 1: value_in is valid.
REQ-007 SHALL have port ready_out, output, 1: block accepts value_in this cycle.
REQ-008 SHALL have port frame_start_in, input, 1: one-cycle pulse at the first pixel of a frame (hcount=0, vcount=0).
REQ-009 SHALL have port digits_out, output, 4*NUM_DIGITS: digit i occupies bits [4i+3:4i], with digit 0 as the ones digit; each nibble drives a sprite "number" input.
REQ-010 SHALL have port digit_en_out, output, NUM_DIGITS: 1 means draw digit i; 0 means leading-zero blank.
REQ-011 SHALL have port overflow_out, output, 1: the displayed value was saturated.
REQ-012 SHALL have port busy_out, output, 1: a conversion or commit is pending.

Function
REQ-013 SHALL implement FSM states IDLE, CONVERT and PENDING.
REQ-014 SHALL assert ready_out only in IDLE; busy_out SHALL equal NOT ready_out.
REQ-015 SHALL accept a transfer only when valid_in AND ready_out are both high; valid_in while ready_out is low SHALL be ignored and SHALL have no side effects.
REQ-016 On acceptance, SHALL capture min(value_in, 10^NUM_DIGITS-1), set the internal overflow flag to (value_in > 10^NUM_DIGITS-1), clear the BCD scratch register, clear the step counter, and move to CONVERT.
REQ-017 In CONVERT, each cycle SHALL add 3 to every scratch nibble that is >=5, then shift {scratch, binary} left by 1 (double-dabble).
REQ-018 SHALL run exactly BIN_WIDTH CONVERT cycles, then move to PENDING.
REQ-019 SHALL keep digits_out, digit_en_out and overflow_out stable outside a commit, so no digit changes mid-frame.
REQ-020 In PENDING, on frame_start_in, SHALL register scratch into digits_out and the overflow flag into overflow_out, then return to IDLE; outputs SHALL update on the edge after the pulse.
REQ-021 SHALL ignore frame_start_in in IDLE and CONVERT; a pulse during the final CONVERT cycle SHALL NOT commit.
REQ-022 Latency: with acceptance at edge 0, SHALL enter PENDING at edge BIN_WIDTH+1 and commit at the first frame_start_in sampled in PENDING.
REQ-023 SHALL set digit_en_out[i] = 1 if any digit j>=i is nonzero, and SHALL set digit_en_out[0] = 1 always.
REQ-024 SHALL compute digit_en_out from the committed digits, registered at the same time as digits_out.
REQ-025 SHALL size the step counter as clog2(BIN_WIDTH+1); there SHALL be no wrap beyond BIN_WIDTH.

Reset
REQ-026 While rst_in=0, SHALL force state to IDLE, digits_out to 0, digit_en_out to 'b1, overflow_out to 0 and the scratch register to 0.
REQ-027 While rst_in=0, SHALL hold ready_out at 0; ready_out SHALL assert on the first edge after release.
REQ-028 Reset asserted during CONVERT or PENDING SHALL abort the conversion; the uncommitted value SHALL never appear on any output.

Structure
REQ-029 Package score_pkg SHALL hold the FSM state enum, BIN_WIDTH and NUM_DIGITS defaults, and MAX_VALUE = 10^NUM_DIGITS-1.
REQ-030 The per-nibble add-3 correction SHALL be a combinational sub-module bcd_dabble_step (scratch in, corrected scratch out), instantiated once.
REQ-031 All other logic SHALL be sequential and SHALL live in score_digit_formatter.

Verification
REQ-032 value_in=1234 accepted, then frame_start_in at cycle 20 -> at cycle 21 digits_out=16'h1234, digit_en_out=4'b1111, overflow_out=0.
REQ-033 value_in=7 -> after commit, digits_out=16'h0007, digit_en_out=4'b0001.
REQ-034 value_in=12000 -> after commit, digits_out=16'h9999, overflow_out=1.
REQ-035 frame_start_in pulsed at acceptance+5 and acceptance+14 -> no output change; a pulse at acceptance+16 -> commit; valid_in held high during busy -> the second value is accepted only after returning to IDLE.
REQ-036 rst_in pulled low at acceptance+8 with 4321 in flight -> digits_out stays 0 and ready_out=1 one edge after release.
REQ-037 Value 0 -> digits_out=0, digit_en_out=4'b0001.
